// File: rtl/btb_update_sched.sv
`default_nettype none
// =============================================================================
// Module  : btb_update_sched
// Brief   : Two-lane resolved-branch update queue feeding the single BTB write
//           port. Optional same-PC coalescing when BTB_UPDATE_COALESCE_EN is set.
// Revision: 1.0
// =============================================================================
module btb_update_sched #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INDEX_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btb_ready,
  input  logic [1:0]               req_valid,
  input  logic [1:0][31:0]         req_pc,
  input  logic [1:0][31:0]         req_target,
  input  logic [1:0][1:0]          req_cf,
  output logic                     req_ready,
  input  logic                     mispredict,
  input  logic [31:0]              mispredict_pc,
  output logic                     update_valid,
  output logic [31:0]              update_pc,
  output logic [31:0]              update_target,
  output logic [1:0]               update_cf,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned TAG_HI = INDEX_W + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [0:0] {
    WAIT_BTB = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  logic [31:0] pc_q  [DEPTH];
  logic [31:0] pc_d  [DEPTH];
  logic [31:0] tgt_q [DEPTH];
  logic [31:0] tgt_d [DEPTH];
  logic [1:0]  cf_q  [DEPTH];
  logic [1:0]  cf_d  [DEPTH];

  logic             empty;
  logic             conflict;
  logic             deq;
  logic [1:0]       accept;
  logic [1:0]       n_push;
  logic [PTR_W-1:0] slot;
  logic [31:0]      head_pc;
  logic             unused_pc_bits;

  // Only the index and bank bits take part in the clear-conflict compare.
  assign unused_pc_bits = ^{mispredict_pc[31:TAG_HI+1], mispredict_pc[1:0]};

  assign empty         = (occ_q == '0);
  assign head_pc       = pc_q[rd_ptr_q];
  assign conflict      = mispredict && (mispredict_pc[TAG_HI:2] == head_pc[TAG_HI:2]);
  assign deq           = (state_q == RUN) && !empty && !conflict;
  assign update_valid  = deq;
  assign update_pc     = empty ? '0 : head_pc;
  assign update_target = empty ? '0 : tgt_q[rd_ptr_q];
  assign update_cf     = empty ? '0 : cf_q[rd_ptr_q];
  assign req_ready     = (DEPTH_C - occ_q) >= CNT_W'(2);
  assign occupancy     = occ_q;
  assign accept        = req_valid & {2{req_ready}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_BTB: if (btb_ready)  state_d = RUN;
      RUN:      if (!btb_ready) state_d = WAIT_BTB;
      default:  state_d = WAIT_BTB;
    endcase
  end

`ifdef BTB_UPDATE_COALESCE_EN
  logic [PTR_W-1:0] tail_ptr;
  logic             tail_ok;
  logic [1:0]       lane_en;

  // The tail may only be merged into when it is not leaving this cycle.
  assign tail_ptr = wr_ptr_q - PTR_W'(1);
  assign tail_ok  = !empty && !(deq && (occ_q == CNT_W'(1)));
`endif

  always_comb begin
    pc_d   = pc_q;
    tgt_d  = tgt_q;
    cf_d   = cf_q;
    slot   = wr_ptr_q;
    n_push = '0;
`ifdef BTB_UPDATE_COALESCE_EN
    lane_en = accept;
    if ((accept == 2'b11) && (req_pc[0] == req_pc[1])) lane_en = 2'b10;
    for (int l = 0; l < 2; l++) begin
      if (lane_en[l]) begin
        // Lane 1 may only merge with the old tail if lane 0 did not allocate.
        if (tail_ok && ((l == 0) || !lane_en[0]) && (req_pc[l] == pc_q[tail_ptr])) begin
          tgt_d[tail_ptr] = req_target[l];
          cf_d[tail_ptr]  = req_cf[l];
        end else begin
          pc_d[slot]  = req_pc[l];
          tgt_d[slot] = req_target[l];
          cf_d[slot]  = req_cf[l];
          slot        = slot + PTR_W'(1);
          n_push      = n_push + 2'd1;
        end
      end
    end
`else
    for (int l = 0; l < 2; l++) begin
      if (accept[l]) begin
        pc_d[slot]  = req_pc[l];
        tgt_d[slot] = req_target[l];
        cf_d[slot]  = req_cf[l];
        slot        = slot + PTR_W'(1);
        n_push      = n_push + 2'd1;
      end
    end
`endif
    wr_ptr_d = slot;
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    occ_d    = occ_q + CNT_W'(n_push) - CNT_W'(deq);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= WAIT_BTB;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    pc_q  <= pc_d;
    tgt_q <= tgt_d;
    cf_q  <= cf_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_btb_update_sched.sv
`default_nettype none
// =============================================================================
// Module  : tb_btb_update_sched
// Brief   : Directed self-checking bench for btb_update_sched (DEPTH=4).
// Revision: 1.0
// =============================================================================
module tb_btb_update_sched;

  logic            clk = 1'b0;
  logic            rst;
  logic            btb_ready;
  logic [1:0]      req_valid;
  logic [1:0][31:0] req_pc;
  logic [1:0][31:0] req_target;
  logic [1:0][1:0] req_cf;
  logic            req_ready;
  logic            mispredict;
  logic [31:0]     mispredict_pc;
  logic            update_valid;
  logic [31:0]     update_pc;
  logic [31:0]     update_target;
  logic [1:0]      update_cf;
  logic [2:0]      occupancy;

  int checks   = 0;
  int failures = 0;

  btb_update_sched #(.DEPTH(4), .INDEX_W(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .btb_ready    (btb_ready),
    .req_valid    (req_valid),
    .req_pc       (req_pc),
    .req_target   (req_target),
    .req_cf       (req_cf),
    .req_ready    (req_ready),
    .mispredict   (mispredict),
    .mispredict_pc(mispredict_pc),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_target(update_target),
    .update_cf    (update_cf),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Settle, then compare the write port and occupancy for the current cycle.
  task automatic chk(input string tag, input logic uv, input logic [31:0] pc,
                     input logic [31:0] tgt, input logic [1:0] cf, input int occ);
    #1;
    check({tag, ".valid"}, 32'(update_valid), 32'(uv));
    check({tag, ".occ"}, 32'(occupancy), 32'(occ));
    if (uv) begin
      check({tag, ".pc"}, update_pc, pc);
      check({tag, ".tgt"}, update_target, tgt);
      check({tag, ".cf"}, 32'(update_cf), 32'(cf));
    end
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    check({tag, ".rdy"}, 32'(req_ready), 32'(exp));
  endtask

  task automatic push1(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] cf);
    req_pc[0] = pc; req_target[0] = tgt; req_cf[0] = cf;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
  endtask

  task automatic push2(input logic [31:0] pc0, input logic [31:0] t0, input logic [1:0] c0,
                       input logic [31:0] pc1, input logic [31:0] t1, input logic [1:0] c1);
    req_pc[0] = pc0; req_target[0] = t0; req_cf[0] = c0;
    req_pc[1] = pc1; req_target[1] = t1; req_cf[1] = c1;
    req_valid = 2'b11;
    tick();
    req_valid = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; btb_ready = 1'b0; req_valid = '0; req_pc = '0; req_target = '0;
    req_cf = '0; mispredict = 1'b0; mispredict_pc = '0;
    tick(); tick();
    // Reset state
    #1;
    check("rst.valid", 32'(update_valid), 32'd0);
    check("rst.occ", 32'(occupancy), 32'd0);
    check("rst.rdy", 32'(req_ready), 32'd1);
    check("rst.pc", update_pc, 32'd0);
    check("rst.tgt", update_target, 32'd0);
    check("rst.cf", 32'(update_cf), 32'd0);

    // Held while BTB clears, one update the cycle after btb_ready rises
    rst = 1'b1;
    tick(); tick();
    push1(32'h1000, 32'hAAA0, 2'd1);
    for (int i = 0; i < 5; i++) begin
      chk("wait", 1'b0, 0, 0, 0, 1);
      tick();
    end
    btb_ready = 1'b1;
    chk("wait_last", 1'b0, 0, 0, 0, 1);
    tick();
    chk("first_upd", 1'b1, 32'h1000, 32'hAAA0, 2'd1, 1);
    tick();
    chk("first_done", 1'b0, 0, 0, 0, 0);

    // Two lanes in one cycle drain in lane order
    chk_rdy("two_lane", 1'b1);
    push2(32'h2000, 32'h100, 2'd2, 32'h2004, 32'h104, 2'd3);
    chk("lane0", 1'b1, 32'h2000, 32'h100, 2'd2, 2);
    tick();
    chk("lane1", 1'b1, 32'h2004, 32'h104, 2'd3, 1);
    tick();
    chk("lanes_done", 1'b0, 0, 0, 0, 0);

    // Clear conflict holds the head
    mispredict = 1'b1; mispredict_pc = 32'h3004;
    push1(32'h3004, 32'h300, 2'd1);
    chk("hold1", 1'b0, 0, 0, 0, 1);
    tick();
    chk("hold2", 1'b0, 0, 0, 0, 1);
    tick();
    mispredict = 1'b0;
    chk("hold_rel", 1'b1, 32'h3004, 32'h300, 2'd1, 1);
    tick();
    mispredict = 1'b1; mispredict_pc = 32'h3000;
    push1(32'h3004, 32'h301, 2'd2);
    chk("other_bank", 1'b1, 32'h3004, 32'h301, 2'd2, 1);
    tick();
    mispredict_pc = 32'h3014;
    push1(32'h3004, 32'h302, 2'd0);
    chk("other_index", 1'b1, 32'h3004, 32'h302, 2'd0, 1);
    tick();
    mispredict_pc = 32'h0008_3004;
    push1(32'h3004, 32'h303, 2'd3);
    chk("upper_bits_hold", 1'b0, 0, 0, 0, 1);
    mispredict = 1'b0;
    chk("upper_rel", 1'b1, 32'h3004, 32'h303, 2'd3, 1);
    tick();
    chk("hold_done", 1'b0, 0, 0, 0, 0);

    // Fill with btb_ready low, backpressure, wrap while draining
    btb_ready = 1'b0;
    tick();
    push2(32'h5000, 32'h500, 2'd0, 32'h5004, 32'h504, 2'd1);
    chk("fill2", 1'b0, 0, 0, 0, 2);
    chk_rdy("fill2", 1'b1);
    push1(32'h5008, 32'h508, 2'd2);
    chk("fill3", 1'b0, 0, 0, 0, 3);
    chk_rdy("fill3", 1'b0);
    req_pc[0] = 32'hDEAD_0000; req_pc[1] = 32'hDEAD_0004; req_valid = 2'b11;
    tick();
    req_valid = 2'b00;
    chk("ignored", 1'b0, 0, 0, 0, 3);
    btb_ready = 1'b1;
    tick();
    chk("drain0", 1'b1, 32'h5000, 32'h500, 2'd0, 3);
    chk_rdy("drain0", 1'b0);
    tick();
    chk("drain1", 1'b1, 32'h5004, 32'h504, 2'd1, 2);
    chk_rdy("drain1", 1'b1);
    push2(32'h6000, 32'h600, 2'd3, 32'h6004, 32'h604, 2'd2);
    chk("drain2", 1'b1, 32'h5008, 32'h508, 2'd2, 3);
    chk_rdy("drain2", 1'b0);
    tick();
    chk("drain3", 1'b1, 32'h6000, 32'h600, 2'd3, 2);
    tick();
    chk("drain4", 1'b1, 32'h6004, 32'h604, 2'd2, 1);
    tick();
    chk("drain_done", 1'b0, 0, 0, 0, 0);

    // Full queue with a dequeue keeps req_ready low for that cycle
    btb_ready = 1'b0;
    tick();
    push2(32'h8000, 32'h800, 2'd0, 32'h8004, 32'h804, 2'd1);
    push2(32'h8008, 32'h808, 2'd2, 32'h800C, 32'h80C, 2'd3);
    chk("full", 1'b0, 0, 0, 0, 4);
    chk_rdy("full", 1'b0);
    btb_ready = 1'b1;
    tick();
    chk("full_deq", 1'b1, 32'h8000, 32'h800, 2'd0, 4);
    chk_rdy("full_deq", 1'b0);
    tick();
    chk("full_3", 1'b1, 32'h8004, 32'h804, 2'd1, 3);
    chk_rdy("full_3", 1'b0);
    tick();
    chk("full_2", 1'b1, 32'h8008, 32'h808, 2'd2, 2);
    chk_rdy("full_2", 1'b1);
    tick();
    chk("full_1", 1'b1, 32'h800C, 32'h80C, 2'd3, 1);
    tick();
    chk("full_done", 1'b0, 0, 0, 0, 0);

    // Same PC back-to-back while held
    btb_ready = 1'b0;
    tick();
    push1(32'h4000, 32'h10, 2'd1);
    push1(32'h4000, 32'h20, 2'd2);
`ifdef BTB_UPDATE_COALESCE_EN
    chk("same_pc_held", 1'b0, 0, 0, 0, 1);
    btb_ready = 1'b1;
    tick();
    chk("same_pc_upd", 1'b1, 32'h4000, 32'h20, 2'd2, 1);
    tick();
`else
    chk("same_pc_held", 1'b0, 0, 0, 0, 2);
    btb_ready = 1'b1;
    tick();
    chk("same_pc_upd0", 1'b1, 32'h4000, 32'h10, 2'd1, 2);
    tick();
    chk("same_pc_upd1", 1'b1, 32'h4000, 32'h20, 2'd2, 1);
    tick();
`endif
    chk("same_pc_done", 1'b0, 0, 0, 0, 0);

    // Same PC on both lanes in one cycle
    btb_ready = 1'b0;
    tick();
    push2(32'h4100, 32'h30, 2'd0, 32'h4100, 32'h40, 2'd3);
`ifdef BTB_UPDATE_COALESCE_EN
    chk("dual_same_held", 1'b0, 0, 0, 0, 1);
    btb_ready = 1'b1;
    tick();
    chk("dual_same_upd", 1'b1, 32'h4100, 32'h40, 2'd3, 1);
    tick();
`else
    chk("dual_same_held", 1'b0, 0, 0, 0, 2);
    btb_ready = 1'b1;
    tick();
    chk("dual_same_upd0", 1'b1, 32'h4100, 32'h30, 2'd0, 2);
    tick();
    chk("dual_same_upd1", 1'b1, 32'h4100, 32'h40, 2'd3, 1);
    tick();
`endif
    chk("dual_same_done", 1'b0, 0, 0, 0, 0);

    // Reset with queued entries discards them
    btb_ready = 1'b0;
    tick();
    push2(32'h9000, 32'h900, 2'd1, 32'h9004, 32'h904, 2'd2);
    push1(32'h9008, 32'h908, 2'd3);
    chk("pre_rst", 1'b0, 0, 0, 0, 3);
    rst = 1'b0;
    btb_ready = 1'b1;
    tick();
    chk("mid_rst", 1'b0, 0, 0, 0, 0);
    chk_rdy("mid_rst", 1'b1);
    check("mid_rst.pc", update_pc, 32'd0);
    check("mid_rst.tgt", update_target, 32'd0);
    rst = 1'b1;
    chk("post_rst0", 1'b0, 0, 0, 0, 0);
    tick();
    chk("post_rst1", 1'b0, 0, 0, 0, 0);
    push1(32'h7000, 32'h700, 2'd1);
    chk("post_rst_upd", 1'b1, 32'h7000, 32'h700, 2'd1, 1);
    tick();
    chk("post_rst_done", 1'b0, 0, 0, 0, 0);
    tick();
    chk("no_stale", 1'b0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
